// File: rtl/csa_accum_n_pkg.sv
// Shared definitions for the iterative carry-save accumulator.
//   state_e       : FSM state encoding (IDLE / ACCUM / DONE)
//   DefaultWidth  : default datapath width
//   DefaultCntW   : default width of the iteration-count input
package csa_accum_n_pkg;

  localparam int unsigned DefaultWidth = 64;
  localparam int unsigned DefaultCntW  = 3;

  typedef enum logic [1:0] {
    StIdle  = 2'b00,
    StAccum = 2'b01,
    StDone  = 2'b10
  } state_e;

endpackage

// File: rtl/csa_accum_n_comp42_row.sv
// Combinational row of 4:2 compressors with an internal ci/cout ripple of one bit.
// Reduces four WIDTH-bit words to a redundant sum/carry pair, modulo 2^WIDTH.
//   a_i, b_i  : new partial-product rows
//   s_i, c_i  : held sum / carry words
//   sum_o     : new sum word (S0 of every cell)
//   carry_o   : new carry word ({S1[WIDTH-2:0], 1'b0})
module csa_accum_n_comp42_row #(
  parameter int unsigned WIDTH = 64
) (
  input  logic [WIDTH-1:0] a_i,
  input  logic [WIDTH-1:0] b_i,
  input  logic [WIDTH-1:0] s_i,
  input  logic [WIDTH-1:0] c_i,
  output logic [WIDTH-1:0] sum_o,
  output logic [WIDTH-1:0] carry_o
);

  logic [WIDTH-1:0] t;
  logic [WIDTH-1:0] ci;
  // The top cell's cout and S1 fall outside the modulus, so they are never built.
  logic [WIDTH-2:0] cout;
  logic [WIDTH-2:0] s1;

  assign ci[0] = 1'b0;

  for (genvar i = 0; i < WIDTH; i++) begin : g_cell
    // First full adder over a,b,s: its carry is cout, which never depends on ci.
    assign t[i]     = a_i[i] ^ b_i[i] ^ s_i[i];
    // Second full adder folds in c and the neighbour's cout.
    assign sum_o[i] = t[i] ^ c_i[i] ^ ci[i];
    if (i != WIDTH - 1) begin : g_upper
      assign cout[i]  = (a_i[i] & b_i[i]) | (a_i[i] & s_i[i]) | (b_i[i] & s_i[i]);
      assign s1[i]    = (t[i] & c_i[i]) | (t[i] & ci[i]) | (c_i[i] & ci[i]);
      assign ci[i+1]  = cout[i];
    end
  end

  assign carry_o = {s1, 1'b0};

endmodule

// File: rtl/csa_accum_n.sv
// Iterative carry-save accumulator. Each accepted beat compresses two new partial-product
// rows into the held sum/carry pair; after n_iter_i beats the redundant result is offered
// to the final carry-propagate adder.
//   nGCLK, nRESET         : clock (rising edge), asynchronous active-low reset
//   start_i, n_iter_i     : begin an operation with the given beat count (IDLE only)
//   init_sum_i/carry_i    : initial redundant value (MLA accumulator, else 0)
//   abort_i               : synchronous abort back to IDLE, highest priority
//   pp_valid_i/ready_o    : partial-product beat handshake, rows pp_a_i / pp_b_i
//   out_valid_o/ready_i   : result handshake, result on sum_o / carry_o
//   busy_o                : high whenever not IDLE
module csa_accum_n
  import csa_accum_n_pkg::*;
#(
  parameter int unsigned WIDTH = DefaultWidth,
  parameter int unsigned CNT_W = DefaultCntW
) (
  input  logic             nGCLK,
  input  logic             nRESET,
  input  logic             start_i,
  input  logic [CNT_W-1:0] n_iter_i,
  input  logic [WIDTH-1:0] init_sum_i,
  input  logic [WIDTH-1:0] init_carry_i,
  input  logic             abort_i,
  input  logic             pp_valid_i,
  input  logic [WIDTH-1:0] pp_a_i,
  input  logic [WIDTH-1:0] pp_b_i,
  output logic             pp_ready_o,
  output logic             out_valid_o,
  input  logic             out_ready_i,
  output logic [WIDTH-1:0] sum_o,
  output logic [WIDTH-1:0] carry_o,
  output logic             busy_o
);

  state_e           state_q, state_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic [WIDTH-1:0] sum_q, sum_d;
  logic [WIDTH-1:0] carry_q, carry_d;
  logic [WIDTH-1:0] comp_sum;
  logic [WIDTH-1:0] comp_carry;

  csa_accum_n_comp42_row #(
    .WIDTH (WIDTH)
  ) u_row (
    .a_i     (pp_a_i),
    .b_i     (pp_b_i),
    .s_i     (sum_q),
    .c_i     (carry_q),
    .sum_o   (comp_sum),
    .carry_o (comp_carry)
  );

  always_comb begin
    state_d = state_q;
    count_d = count_q;
    sum_d   = sum_q;
    carry_d = carry_q;

    if (abort_i) begin
      // Abort keeps the partial result visible but forgets the operation.
      state_d = StIdle;
      count_d = '0;
    end else begin
      unique case (state_q)
        StIdle: begin
          if (start_i) begin
            sum_d   = init_sum_i;
            carry_d = init_carry_i;
            count_d = n_iter_i;
            state_d = (n_iter_i != '0) ? StAccum : StDone;
          end
        end
        StAccum: begin
          if (pp_valid_i) begin
            sum_d   = comp_sum;
            carry_d = comp_carry;
            if (count_q != '0) begin
              count_d = count_q - CNT_W'(1);
            end
            if (count_q <= CNT_W'(1)) begin
              state_d = StDone;
            end
          end
        end
        StDone: begin
          if (out_ready_i) begin
            state_d = StIdle;
          end
        end
        default: begin
          state_d = StIdle;
          count_d = '0;
        end
      endcase
    end
  end

  always_ff @(posedge nGCLK or negedge nRESET) begin
    if (!nRESET) begin
      state_q <= StIdle;
      count_q <= '0;
      sum_q   <= '0;
      carry_q <= '0;
    end else begin
      state_q <= state_d;
      count_q <= count_d;
      sum_q   <= sum_d;
      carry_q <= carry_d;
    end
  end

  always_comb begin
    pp_ready_o  = (state_q == StAccum) && !abort_i;
    out_valid_o = (state_q == StDone);
    busy_o      = (state_q != StIdle);
    sum_o       = sum_q;
    carry_o     = carry_q;
  end

endmodule

// File: tb/tb_csa_accum_n.sv
// Directed bench for csa_accum_n at WIDTH=64, CNT_W=3.
module tb_csa_accum_n;

  localparam int unsigned WIDTH = 64;
  localparam int unsigned CNT_W = 3;

  logic             clk;
  logic             rst_n;
  logic             start;
  logic [CNT_W-1:0] n_iter;
  logic [WIDTH-1:0] init_sum;
  logic [WIDTH-1:0] init_carry;
  logic             abort;
  logic             pp_valid;
  logic [WIDTH-1:0] pp_a;
  logic [WIDTH-1:0] pp_b;
  logic             pp_ready;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] sum;
  logic [WIDTH-1:0] carry;
  logic             busy;

  int n_checks = 0;
  int n_pass   = 0;
  int n_hs;

  csa_accum_n #(
    .WIDTH (WIDTH),
    .CNT_W (CNT_W)
  ) dut (
    .nGCLK        (clk),
    .nRESET       (rst_n),
    .start_i      (start),
    .n_iter_i     (n_iter),
    .init_sum_i   (init_sum),
    .init_carry_i (init_carry),
    .abort_i      (abort),
    .pp_valid_i   (pp_valid),
    .pp_a_i       (pp_a),
    .pp_b_i       (pp_b),
    .pp_ready_o   (pp_ready),
    .out_valid_o  (out_valid),
    .out_ready_i  (out_ready),
    .sum_o        (sum),
    .carry_o      (carry),
    .busy_o       (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    if (obs !== exp) begin
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end else begin
      n_pass++;
    end
  endtask

  // Advance one edge and settle just after it.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_start(input logic [CNT_W-1:0] n, input logic [63:0] s,
                          input logic [63:0] c);
    start      = 1'b1;
    n_iter     = n;
    init_sum   = s;
    init_carry = c;
    step();
    start      = 1'b0;
  endtask

  initial begin
    rst_n      = 1'b0;
    start      = 1'b0;
    n_iter     = '0;
    init_sum   = '0;
    init_carry = '0;
    abort      = 1'b0;
    pp_valid   = 1'b0;
    pp_a       = '0;
    pp_b       = '0;
    out_ready  = 1'b0;
    #12;
    check("rst_busy", 64'(busy), 64'd0);
    check("rst_ready", 64'(pp_ready), 64'd0);
    check("rst_valid", 64'(out_valid), 64'd0);
    check("rst_sum", sum, 64'd0);
    check("rst_carry", carry, 64'd0);
    rst_n = 1'b1;
    step();

    // Two back-to-back beats: 3+5+7+11 = 26.
    do_start(3'd2, 64'd0, 64'd0);
    check("t1_busy", 64'(busy), 64'd1);
    pp_valid = 1'b1; pp_a = 64'd3; pp_b = 64'd5;
    #1;
    check("t1_ready", 64'(pp_ready), 64'd1);
    step();
    check("t1_valid_early", 64'(out_valid), 64'd0);
    check("t1_sum_b1", sum, 64'd4);
    check("t1_carry_b1", carry, 64'd4);
    pp_a = 64'd7; pp_b = 64'd11;
    step();
    pp_valid = 1'b0;
    check("t1_valid", 64'(out_valid), 64'd1);
    check("t1_total", sum + carry, 64'd26);
    out_ready = 1'b1;
    step();
    check("t1_idle", 64'(busy), 64'd0);

    // n_iter=0: result is the init pair, DONE lasts exactly one cycle with out_ready high.
    do_start(3'd0, 64'd100, 64'd0);
    check("t2_valid", 64'(out_valid), 64'd1);
    check("t2_busy", 64'(busy), 64'd1);
    check("t2_sum", sum, 64'd100);
    check("t2_carry", carry, 64'd0);
    step();
    check("t2_busy_drop", 64'(busy), 64'd0);
    check("t2_valid_drop", 64'(out_valid), 64'd0);
    out_ready = 1'b0;

    // Toggling valid: only three handshakes; (2^64-1)+1 per beat wraps to 0.
    do_start(3'd3, 64'd0, 64'd0);
    n_hs = 0;
    pp_a = 64'hFFFF_FFFF_FFFF_FFFF;
    pp_b = 64'd1;
    for (int k = 0; k < 5; k++) begin
      pp_valid = (k % 2 == 0);
      #1;
      if (pp_valid && pp_ready) n_hs++;
      if (k == 4) check("t3_valid_early", 64'(out_valid), 64'd0);
      step();
    end
    pp_valid = 1'b0;
    check("t3_handshakes", 64'(n_hs), 64'd3);
    check("t3_valid", 64'(out_valid), 64'd1);
    check("t3_total", sum + carry, 64'd0);
    out_ready = 1'b1;
    step();
    out_ready = 1'b0;
    check("t3_idle", 64'(busy), 64'd0);

    // Held result in DONE; start pulses are ignored.
    do_start(3'd0, 64'h1234, 64'h55);
    for (int k = 0; k < 5; k++) begin
      start = (k % 2 == 0); n_iter = 3'd2; init_sum = 64'hDEAD; init_carry = 64'hBEEF;
      step();
      check("t4_hold_valid", 64'(out_valid), 64'd1);
      check("t4_hold_sum", sum, 64'h1234);
      check("t4_hold_carry", carry, 64'h55);
    end
    start = 1'b0;
    out_ready = 1'b1;
    step();
    out_ready = 1'b0;
    check("t4_idle", 64'(busy), 64'd0);
    check("t4_sum_kept", sum, 64'h1234);

    // Abort with a beat pending after 1 of 3 beats.
    do_start(3'd3, 64'd0, 64'd0);
    pp_valid = 1'b1; pp_a = 64'd1; pp_b = 64'd2;
    step();
    abort = 1'b1; pp_a = 64'd4; pp_b = 64'd8;
    #1;
    check("t5_ready_abort", 64'(pp_ready), 64'd0);
    step();
    abort = 1'b0; pp_valid = 1'b0;
    check("t5_idle", 64'(busy), 64'd0);
    check("t5_total_kept", sum + carry, 64'd3);
    for (int k = 0; k < 3; k++) begin
      step();
      check("t5_no_valid", 64'(out_valid), 64'd0);
    end

    // Asynchronous reset mid-ACCUM, then a fresh one-beat operation: 2+2 = 4.
    do_start(3'd3, 64'd7, 64'd9);
    pp_valid = 1'b1; pp_a = 64'd5; pp_b = 64'd6;
    step();
    pp_valid = 1'b0;
    #2;
    rst_n = 1'b0;
    #1;
    check("t6_rst_busy", 64'(busy), 64'd0);
    check("t6_rst_ready", 64'(pp_ready), 64'd0);
    check("t6_rst_sum", sum, 64'd0);
    check("t6_rst_carry", carry, 64'd0);
    rst_n = 1'b1;
    step();
    do_start(3'd1, 64'd0, 64'd0);
    pp_valid = 1'b1; pp_a = 64'd2; pp_b = 64'd2;
    step();
    pp_valid = 1'b0;
    check("t6_valid", 64'(out_valid), 64'd1);
    check("t6_sum", sum, 64'd4);
    check("t6_carry", carry, 64'd0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
